// File: rtl/mp_adder.sv
// rtl/mp_adder.sv - multi-precision limb-serial adder/subtractor with shift-right-by-one
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous reset, active HIGH (legacy name)
//   start     1-cycle pulse, latches in_a, in_b, subtract when idle
//   subtract  0: a+b, 1: a-b (two's complement, modulo 2^(OP_W+1))
//   shift     1-cycle pulse, result >>= 1 when idle and start is low
//   in_a      operand A (unsigned, OP_W bits)
//   in_b      operand B (unsigned, OP_W bits)
//   result    registered OP_W+1 bit result
//   done      level, high while result is valid and the block is idle
//
// Build option: MP_ADDER_SINGLE_CYCLE_EN computes the full-width sum in one
// RUN cycle instead of one CHUNK_W limb per cycle.
module mp_adder #(
    parameter int OP_W    = 514,
    parameter int CHUNK_W = 128
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic            shift,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic [OP_W:0]   result,
    output logic            done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state;
    state_t state_next;

    logic            load;
    logic            do_shift;
    logic            last;
    logic [OP_W-1:0] a_reg;
    logic [OP_W-1:0] b_reg;
    logic            sub_r;

`ifdef MP_ADDER_SINGLE_CYCLE_EN
    logic [OP_W:0] full_sum;

    // Subtraction as A + ~B + 1 on zero-extended operands; the carry out of
    // bit OP_W falls off the top of the OP_W+1 bit sum.
    always_comb begin
        full_sum = {1'b0, a_reg} + ({1'b0, b_reg} ^ {(OP_W+1){sub_r}}) + (OP_W+1)'(sub_r);
    end
`else
    localparam int NUM_CHUNKS = (OP_W + CHUNK_W) / CHUNK_W;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [PAD_W-1:0]   a_pad;
    logic [PAD_W-1:0]   b_pad;
    logic [CHUNK_W-1:0] a_limb;
    logic [CHUNK_W-1:0] b_limb;
    logic [CHUNK_W:0]   limb_sum;
    logic [OP_W:0]      res_next;

    // The inversion also covers the padding above bit OP_W; those bits only
    // feed carries upward, so they never disturb the kept OP_W+1 bits.
    always_comb begin
        a_pad    = PAD_W'(a_reg);
        b_pad    = PAD_W'(b_reg) ^ {PAD_W{sub_r}};
        a_limb   = a_pad[int'(idx)*CHUNK_W +: CHUNK_W];
        b_limb   = b_pad[int'(idx)*CHUNK_W +: CHUNK_W];
        limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + {{CHUNK_W{1'b0}}, carry};
        res_next = result;
        for (int k = 0; k <= OP_W; k++) begin
            if (k / CHUNK_W == int'(idx)) begin
                res_next[k] = limb_sum[k % CHUNK_W];
            end
        end
    end
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        do_shift   = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                // start has priority; a coincident shift is dropped
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else if (shift) begin
                    do_shift = 1'b1;
                end
            end
            RUN: begin
`ifdef MP_ADDER_SINGLE_CYCLE_EN
                last = 1'b1;
`else
                last = (idx == LAST_IDX);
`endif
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            result <= '0;
            done   <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            sub_r  <= 1'b0;
`ifndef MP_ADDER_SINGLE_CYCLE_EN
            carry  <= 1'b0;
            idx    <= '0;
`endif
        end else if (load) begin
            a_reg  <= in_a;
            b_reg  <= in_b;
            sub_r  <= subtract;
            done   <= 1'b0;
`ifndef MP_ADDER_SINGLE_CYCLE_EN
            carry  <= subtract;
            idx    <= '0;
`endif
        end else if (do_shift) begin
            result <= {1'b0, result[OP_W:1]};
        end else if (state == RUN) begin
`ifdef MP_ADDER_SINGLE_CYCLE_EN
            result <= full_sum;
`else
            result <= res_next;
            carry  <= limb_sum[CHUNK_W];
            idx    <= idx + IDX_W'(1);
`endif
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_adder.sv
// tb/tb_mp_adder.sv - directed self-checking bench for mp_adder
module tb_mp_adder;

    localparam int LAT = 5;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         subtract;
    logic         shift;
    logic [513:0] in_a;
    logic [513:0] in_b;
    logic [514:0] result;
    logic         done;

    int passed;
    int total;

    logic [513:0] ones514;
    logic [513:0] alt10;
    logic [513:0] alt01;
    logic [513:0] p128;
    logic [514:0] exp_v;

    mp_adder dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .subtract (subtract),
        .shift    (shift),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [514:0] obs, input logic [514:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [513:0] a, input logic [513:0] b, input logic sub);
        in_a     = a;
        in_b     = b;
        subtract = sub;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk({tag, "_done_clr"}, 515'(done), 515'd0);
        repeat (LAT - 1) tick();
        chk({tag, "_done_early"}, 515'(done), 515'd0);
        tick();
        chk({tag, "_done"}, 515'(done), 515'd1);
    endtask

    initial begin
        clk      = 1'b0;
        resetn   = 1'b1;
        start    = 1'b0;
        subtract = 1'b0;
        shift    = 1'b0;
        in_a     = '0;
        in_b     = '0;
        passed   = 0;
        total    = 0;
        ones514  = {514{1'b1}};
        alt10    = {257{2'b10}};
        alt01    = {257{2'b01}};
        p128     = 514'd1 << 128;

        #22;
        chk("rst_result", result, 515'd0);
        chk("rst_done", 515'(done), 515'd0);
        #3;
        @(negedge clk);
        resetn = 1'b0;
        tick();
        chk("post_rst_result", result, 515'd0);
        chk("post_rst_done", 515'(done), 515'd0);

        run_op("add_1_1", 514'd1, 514'd1, 1'b0);
        chk("add_1_1_res", result, 515'd2);
        repeat (3) tick();
        chk("add_1_1_hold_done", 515'(done), 515'd1);
        chk("add_1_1_hold_res", result, 515'd2);

        run_op("add_ones_1", ones514, 514'd1, 1'b0);
        chk("add_ones_1_res", result, {1'b1, 514'd0});

        run_op("add_alt", alt10, alt01, 1'b0);
        chk("add_alt_res", result, {1'b0, ones514});

        run_op("add_ones_ones", ones514, ones514, 1'b0);
        chk("add_ones_ones_res", result, {ones514, 1'b0});

        shift = 1'b1;
        tick();
        shift = 1'b0;
        chk("shift1_res", result, {1'b0, ones514});
        chk("shift1_done", 515'(done), 515'd1);
        shift = 1'b1;
        tick();
        shift = 1'b0;
        exp_v = {1'b0, ones514} >> 1;
        chk("shift2_res", result, exp_v);

        run_op("sub_1_1", 514'd1, 514'd1, 1'b1);
        chk("sub_1_1_res", result, 515'd0);

        run_op("sub_0_1", 514'd0, 514'd1, 1'b1);
        chk("sub_0_1_res", result, {515{1'b1}});

        run_op("sub_p128_1", p128, 514'd1, 1'b1);
        exp_v = (515'd1 << 128) - 515'd1;
        chk("sub_p128_1_res", result, exp_v);

        run_op("sub_alt", alt10, alt01, 1'b1);
        chk("sub_alt_res", result, {1'b0, alt01});

        run_op("sub_5_7", 514'd5, 514'd7, 1'b1);
        chk("sub_5_7_res", result, {ones514, 1'b0});

        // operands change right after the start edge; latched copies must be used
        in_a     = 514'd3;
        in_b     = 514'd4;
        subtract = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_a     = 514'd100;
        in_b     = 514'd1;
        subtract = 1'b1;
        repeat (LAT) tick();
        chk("latch_done", 515'(done), 515'd1);
        chk("latch_res", result, 515'd7);

        // start and shift pulses during RUN are ignored
        in_a     = ones514;
        in_b     = ones514;
        subtract = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        in_a     = 514'd5;
        in_b     = 514'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        shift    = 1'b1;
        tick();
        shift    = 1'b0;
        tick();
        chk("busy_done_early", 515'(done), 515'd0);
        tick();
        chk("busy_done", 515'(done), 515'd1);
        chk("busy_res", result, {ones514, 1'b0});

        // start and shift together: start wins
        in_a     = 514'd3;
        in_b     = 514'd4;
        subtract = 1'b0;
        start    = 1'b1;
        shift    = 1'b1;
        tick();
        start    = 1'b0;
        shift    = 1'b0;
        chk("prio_done_clr", 515'(done), 515'd0);
        repeat (LAT) tick();
        chk("prio_done", 515'(done), 515'd1);
        chk("prio_res", result, 515'd7);

        // reset asserted in the third RUN cycle
        in_a     = ones514;
        in_b     = 514'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        tick();
        resetn   = 1'b1;
        #1;
        chk("midrst_res", result, 515'd0);
        chk("midrst_done", 515'(done), 515'd0);
        tick();
        resetn   = 1'b0;
        repeat (6) tick();
        chk("midrst_idle_done", 515'(done), 515'd0);
        chk("midrst_idle_res", result, 515'd0);

        run_op("after_rst", 514'd1, 514'd1, 1'b0);
        chk("after_rst_res", result, 515'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mp_adder.md
Name: mp_adder

Overview:
- Multi-precision, multi-cycle adder/subtractor for the RSA Montgomery datapath.
- Adds or subtracts two 514-bit operands one CHUNK_W-bit limb per cycle with a registered carry.
- Produces a 515-bit registered result that can be shifted right by one bit on command (divide-by-2 step).

Parameters:
- OP_W, 514, operand width in bits.
- CHUNK_W, 128, limb width processed per cycle. Operands are zero/sign-extended to OP_W+1 and padded to NUM_CHUNKS*CHUNK_W.
- NUM_CHUNKS, ceil((OP_W+1)/CHUNK_W) = 5, derived, not overridable.

Ports:
- clk  in  1  single clock, rising-edge.
- resetn  in  1  asynchronous reset, asserted HIGH (name kept for codebase consistency; active-high, asynchronous).
- start  in  1  1-cycle pulse; samples in_a, in_b, subtract.
- subtract  in  1  0: a+b; 1: a-b (two's complement).
- shift  in  1  1-cycle pulse; result <= result >> 1 when idle.
- in_a  in  OP_W  operand A, unsigned.
- in_b  in  OP_W  operand B, unsigned.
- result  out  OP_W+1  registered result.
- done  out  1  high while result is valid and the block is idle.

Behaviour:
- Reset (async, resetn=1): result=0, done=0, FSM=IDLE, carry=0. Reset mid-operation aborts the operation immediately.
- FSM states IDLE, RUN.
  - IDLE + start: latch A, B, subtract; done<=0; carry<=subtract; chunk index<=0; go to RUN.
  - RUN: each cycle computes limb i: sum = A_i + (B_i XOR {CHUNK_W{subtract}}) + carry; stores it in limb i of result; carry<=carry-out.
  - After the last limb (i=NUM_CHUNKS-1): done<=1, go to IDLE.
- Latency: done rises on the NUM_CHUNKS-th rising edge after the edge that sampled start (5 cycles by default).
- done is a level. It stays high until the next accepted start, then clears on that start edge.
- Arithmetic, modulo 2^(OP_W+1):
  - Add: result = A + B, with bit OP_W as carry-out.
  - Subtract: A and B are zero-extended to OP_W+1 bits, and result = A + ~B + 1. When A<B, bit OP_W is 1 and result = 2^(OP_W+1) - (B-A).
  - The final carry beyond bit OP_W is discarded.
- result bits are undefined while in RUN and valid only when done=1.
- shift: in IDLE, on start=0, result <= {1'b0, result[OP_W:1]} (logical). done is unchanged. Shift is repeatable every cycle.
- Simultaneous start and shift in IDLE: start wins and the shift is dropped.
- start or shift during RUN: ignored. Operands are latched, so in_a, in_b and subtract may change after the start cycle.
- Inputs are sampled only on the start edge.

Optional Feature:
- Macro MP_ADDER_SINGLE_CYCLE_EN.
- Defined:
  - Full OP_W+1-bit add/sub is computed combinationally from the latched operands in one cycle.
  - done and result are valid on the first rising edge after the start edge (latency 1).
  - All other rules (done level, shift, priority, reset) are unchanged.
- Undefined: limb-serial behaviour described above, latency NUM_CHUNKS.

Test Plan:
- Reset with resetn=1 for 25 ns, then release -> result=0, done=0.
- add 1+1 -> done after 5 cycles, result=515'h2, done held high until next start.
- add A=514'h26cabac6...72386, B=514'h2a34bae8...25a16a -> result=515'h50ff75ae...bfecc4f0. Then one shift pulse -> result equals prior result >> 1, done still 1.
- sub 1-1 -> result=0. sub 0-1 -> result = all 515 bits set (515'h7ff...f).
- sub A=514'h3f12eada...b63c139, B=514'h3f6837b7...ef276754 -> result=515'h7faab323...79c3c59e5 (bit 514 set).
- Robustness:
  - Assert reset in the 3rd RUN cycle -> done=0, result=0 immediately.
  - start while busy -> ignored.
  - start+shift same cycle -> new op starts, no shift applied.
